// File: rtl/efb_pkg.sv
// Shared MachXO2 EFB definitions: I2C register map, status bits, command codes
// and the Wishbone master state encoding.
package efb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_GAP,
    ST_DONE
  } wb_state_t;

  localparam logic [7:0] EFB_I2C_BASE = 8'h40;
  localparam logic [7:0] I2C_CR       = EFB_I2C_BASE + 8'h0;
  localparam logic [7:0] I2C_CMDR     = EFB_I2C_BASE + 8'h1;
  localparam logic [7:0] I2C_BR0      = EFB_I2C_BASE + 8'h2;
  localparam logic [7:0] I2C_BR1      = EFB_I2C_BASE + 8'h3;
  localparam logic [7:0] I2C_TXDR     = EFB_I2C_BASE + 8'h4;
  localparam logic [7:0] I2C_SR       = EFB_I2C_BASE + 8'h5;
  localparam logic [7:0] I2C_GCDR     = EFB_I2C_BASE + 8'h6;
  localparam logic [7:0] I2C_RXDR     = EFB_I2C_BASE + 8'h7;
  localparam logic [7:0] I2C_IRQ      = EFB_I2C_BASE + 8'h8;
  localparam logic [7:0] I2C_IRQEN    = EFB_I2C_BASE + 8'h9;

  localparam int unsigned SR_TIP   = 7;
  localparam int unsigned SR_BUSY  = 6;
  localparam int unsigned SR_RARC  = 5;
  localparam int unsigned SR_SRW   = 4;
  localparam int unsigned SR_ARBL  = 3;
  localparam int unsigned SR_TRRDY = 2;
  localparam int unsigned SR_TROE  = 1;
  localparam int unsigned SR_HGC   = 0;

  localparam logic [7:0] CMD_STA    = 8'h80;
  localparam logic [7:0] CMD_STO    = 8'h40;
  localparam logic [7:0] CMD_RD     = 8'h20;
  localparam logic [7:0] CMD_WR     = 8'h10;
  localparam logic [7:0] CMD_ACK    = 8'h08;
  localparam logic [7:0] CMD_CKSDIS = 8'h04;
  localparam logic [7:0] CMD_STA_WR = 8'h94;

endpackage

// File: rtl/efb_wb_master.sv
// Wishbone classic master for single 8-bit EFB register accesses, with an
// optional masked status-poll mode and a per-access ack timeout.
module efb_wb_master
  import efb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned POLL_GAP       = 8,
  parameter int unsigned MAX_POLLS      = 255
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_begin,
  input  logic       i_writeEnable,
  input  logic       i_poll,
  input  logic [7:0] i_address,
  input  logic [7:0] i_writeData,
  input  logic [7:0] i_pollMask,
  input  logic [7:0] i_pollValue,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_error,
  output logic [7:0] o_readData,
  output logic       wb_cyc_o,
  output logic       wb_stb_o,
  output logic       wb_we_o,
  output logic [7:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  input  logic       wb_ack_i
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GW = $clog2(POLL_GAP + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] G_LAST = GW'(POLL_GAP - 1);
  localparam logic [7:0]    P_LAST = 8'(MAX_POLLS);

  wb_state_t     r_state, w_next;
  logic [7:0]    r_adr, r_dat, r_mask, r_value, r_rdata, r_pcnt;
  logic          r_we, r_poll, r_error;
  logic [TW-1:0] r_tcnt;
  logic [GW-1:0] r_gcnt;
  logic          w_err, w_match;

  assign w_match = ((wb_dat_i ^ r_value) & r_mask) == 8'h00;

  always_comb begin
    w_next = r_state;
    w_err  = 1'b0;
    case (r_state)
      ST_IDLE:   if (i_begin) w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (wb_ack_i) begin
          if (!r_poll || w_match) begin
            w_next = ST_DONE;
          end else if (r_pcnt == P_LAST) begin
            w_next = ST_DONE;
            w_err  = 1'b1;
          end else begin
            w_next = ST_GAP;
          end
        end else if (r_tcnt == T_LAST) begin
          w_next = ST_DONE;
          w_err  = 1'b1;
        end
      end
      ST_GAP:    if (r_gcnt == G_LAST) w_next = ST_ACCESS;
      ST_DONE:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_adr   <= '0;
      r_dat   <= '0;
      r_we    <= 1'b0;
      r_poll  <= 1'b0;
      r_mask  <= '0;
      r_value <= '0;
      r_rdata <= '0;
      r_pcnt  <= '0;
      r_tcnt  <= '0;
      r_gcnt  <= '0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_error <= w_err;
      case (r_state)
        ST_IDLE: begin
          if (i_begin) begin
            r_adr   <= i_address;
            r_dat   <= i_writeData;
            r_we    <= i_writeEnable & ~i_poll;
            r_poll  <= i_poll;
            r_mask  <= i_pollMask;
            r_value <= i_pollValue;
          end
          r_pcnt <= 8'd1;
          r_tcnt <= '0;
        end
        ST_ACCESS: begin
          r_tcnt <= r_tcnt + 1'b1;
          r_gcnt <= '0;
          if (wb_ack_i && !r_we) r_rdata <= wb_dat_i;
        end
        ST_GAP: begin
          r_gcnt <= r_gcnt + 1'b1;
          // each re-entry into ACCESS is a new read with a fresh timeout
          if (r_gcnt == G_LAST) begin
            r_tcnt <= '0;
            r_pcnt <= r_pcnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_cyc_o   = (r_state == ST_ACCESS);
  assign wb_stb_o   = (r_state == ST_ACCESS);
  assign wb_we_o    = r_we;
  assign wb_adr_o   = r_adr;
  assign wb_dat_o   = r_dat;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = (r_state == ST_DONE);
  assign o_error    = (r_state == ST_DONE) && r_error;
  assign o_readData = r_rdata;

endmodule

// File: tb/tb_efb_wb_master.sv
// Directed bench for efb_wb_master: vector table plus hand-written
// begin-in-DONE, stray-ack and reset-mid-access sequences.
module tb_efb_wb_master;

  localparam int unsigned TMO = 16;
  localparam int unsigned GAP = 3;
  localparam int unsigned MAXP = 4;

  logic       i_clk = 1'b0;
  logic       i_reset, i_begin, i_writeEnable, i_poll;
  logic [7:0] i_address, i_writeData, i_pollMask, i_pollValue;
  logic       o_busy, o_done, o_error;
  logic [7:0] o_readData;
  logic       wb_cyc_o, wb_stb_o, wb_we_o;
  logic [7:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic       wb_ack_i;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  efb_wb_master #(
    .TIMEOUT_CYCLES(TMO),
    .POLL_GAP      (GAP),
    .MAX_POLLS     (MAXP)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_begin      (i_begin),
    .i_writeEnable(i_writeEnable),
    .i_poll       (i_poll),
    .i_address    (i_address),
    .i_writeData  (i_writeData),
    .i_pollMask   (i_pollMask),
    .i_pollValue  (i_pollValue),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_error      (o_error),
    .o_readData   (o_readData),
    .wb_cyc_o     (wb_cyc_o),
    .wb_stb_o     (wb_stb_o),
    .wb_we_o      (wb_we_o),
    .wb_adr_o     (wb_adr_o),
    .wb_dat_o     (wb_dat_o),
    .wb_dat_i     (wb_dat_i),
    .wb_ack_i     (wb_ack_i)
  );

  // k = STB cycles until ack (ack in the k-th one), 0 = never ack.
  // rdq holds successive read data, byte 0 first.
  typedef struct {
    string       name;
    logic        we;
    logic        poll;
    logic [7:0]  adr;
    logic [7:0]  wdat;
    logic [7:0]  mask;
    logic [7:0]  val;
    int          k;
    logic [31:0] rdq;
    int          exp_done;
    int          exp_stb;
    logic        exp_err;
    logic        exp_we;
    logic [7:0]  exp_rdata;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic txn(input vec_t v, output int done_cyc, output int stb_cyc,
                     output logic err, output logic bus_ok, output logic busy_ok);
    int cyc, acc, idx;
    i_writeEnable = v.we;
    i_poll        = v.poll;
    i_address     = v.adr;
    i_writeData   = v.wdat;
    i_pollMask    = v.mask;
    i_pollValue   = v.val;
    i_begin       = 1'b1;
    step();
    i_begin  = 1'b0;
    cyc      = 1;
    acc      = 0;
    idx      = 0;
    stb_cyc  = 0;
    done_cyc = -1;
    err      = 1'b0;
    bus_ok   = 1'b1;
    busy_ok  = 1'b1;
    while (cyc < 300) begin
      wb_ack_i = 1'b0;
      wb_dat_i = 8'hEE;
      if (o_done) begin
        done_cyc = cyc;
        err      = o_error;
        break;
      end
      if (!o_busy) busy_ok = 1'b0;
      if (wb_stb_o) begin
        stb_cyc++;
        acc++;
        if (!wb_cyc_o || wb_adr_o !== v.adr || wb_we_o !== v.exp_we || wb_dat_o !== v.wdat)
          bus_ok = 1'b0;
        if (acc == v.k) begin
          wb_ack_i = 1'b1;
          wb_dat_i = v.rdq[8*idx +: 8];
          if (idx < 3) idx++;
        end
      end else begin
        acc = 0;
      end
      step();
      cyc++;
    end
    wb_ack_i = 1'b0;
  endtask

  initial begin
    int   dc, sc, seen;
    logic er, bo, bz;

    //         name         we    poll  adr    wdat   mask   val    k  rdq            done stb err  we    rdata
    vecs[0] = '{"wr_cr",     1'b1, 1'b0, 8'h40, 8'h80, 8'h00, 8'h00, 1, 32'h000000FF,  2,   1,  1'b0, 1'b1, 8'h00};
    vecs[1] = '{"rd_rxdr",   1'b0, 1'b0, 8'h47, 8'h00, 8'h00, 8'h00, 3, 32'h0000005A,  4,   3,  1'b0, 1'b0, 8'h5A};
    vecs[2] = '{"wr_cmdr",   1'b1, 1'b0, 8'h41, 8'h94, 8'h00, 8'h00, 2, 32'h000000FF,  3,   2,  1'b0, 1'b1, 8'h5A};
    vecs[3] = '{"poll_3rd",  1'b0, 1'b1, 8'h45, 8'h00, 8'h04, 8'h04, 1, 32'h00040000, 10,   3,  1'b0, 1'b0, 8'h04};
    vecs[4] = '{"poll_1st",  1'b0, 1'b1, 8'h45, 8'h00, 8'hF0, 8'hA0, 2, 32'h000000A5,  3,   2,  1'b0, 1'b0, 8'hA5};
    vecs[5] = '{"poll_exh",  1'b0, 1'b1, 8'h45, 8'h00, 8'h04, 8'h04, 1, 32'h00000000, 14,   4,  1'b1, 1'b0, 8'h00};
    vecs[6] = '{"timeout",   1'b0, 1'b0, 8'h45, 8'h00, 8'h00, 8'h00, 0, 32'h00000000, 17,  16,  1'b1, 1'b0, 8'h00};
    vecs[7] = '{"poll_weign",1'b1, 1'b1, 8'h45, 8'h11, 8'h01, 8'h00, 1, 32'h0000003C,  2,   1,  1'b0, 1'b0, 8'h3C};

    i_reset = 1'b1; i_begin = 1'b0; i_writeEnable = 1'b0; i_poll = 1'b0;
    i_address = 8'h00; i_writeData = 8'h00; i_pollMask = 8'h00; i_pollValue = 8'h00;
    wb_ack_i = 1'b0; wb_dat_i = 8'h00;
    repeat (3) step();
    i_reset = 1'b0;
    step();

    chk("rst_outputs", {o_busy, o_done, o_error, wb_cyc_o, wb_stb_o, wb_we_o}, 6'b0);
    chk("rst_data", {o_readData, wb_adr_o, wb_dat_o}, 24'h0);

    foreach (vecs[i]) begin
      txn(vecs[i], dc, sc, er, bo, bz);
      chk({vecs[i].name, "_done_cyc"}, dc, vecs[i].exp_done);
      chk({vecs[i].name, "_stb_cyc"}, sc, vecs[i].exp_stb);
      chk({vecs[i].name, "_error"}, er, vecs[i].exp_err);
      chk({vecs[i].name, "_rdata"}, o_readData, vecs[i].exp_rdata);
      chk({vecs[i].name, "_bus"}, bo, 1'b1);
      chk({vecs[i].name, "_busy"}, bz, 1'b1);
      step();
      chk({vecs[i].name, "_idle_after"}, {o_busy, o_done, wb_stb_o}, 3'b0);
    end

    // begin raised during the DONE cycle must be dropped
    txn(vecs[0], dc, sc, er, bo, bz);
    chk("done_begin_pre", dc, 2);
    i_begin = 1'b1;
    step();
    i_begin = 1'b0;
    chk("done_begin_stb", wb_stb_o, 1'b0);
    chk("done_begin_busy", o_busy, 1'b0);
    step();
    chk("done_begin_still_idle", {o_busy, wb_stb_o}, 2'b0);

    // stray ack while idle
    wb_ack_i = 1'b1;
    wb_dat_i = 8'hC3;
    step();
    wb_ack_i = 1'b0;
    chk("stray_ack_done", {o_done, o_busy}, 2'b0);
    chk("stray_ack_rdata", o_readData, 8'h3C);

    // begin pulsed mid-access, then reset mid-access
    i_writeEnable = 1'b0; i_poll = 1'b0; i_address = 8'h45; i_writeData = 8'h12;
    i_begin = 1'b1;
    step();
    i_begin = 1'b0;
    chk("mid_stb_on", {wb_cyc_o, wb_stb_o}, 2'b11);
    step();
    i_address = 8'h4A; i_writeData = 8'h77; i_writeEnable = 1'b1;
    i_begin = 1'b1;
    step();
    i_begin = 1'b0;
    chk("mid_begin_adr", wb_adr_o, 8'h45);
    chk("mid_begin_dat", {wb_we_o, wb_dat_o}, 9'h012);
    i_reset = 1'b1;
    step();
    chk("mid_rst_bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o}, 19'h0);
    chk("mid_rst_stat", {o_busy, o_done, o_error, o_readData}, 11'h0);
    step();
    i_reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      if (o_done || wb_stb_o) seen++;
      step();
    end
    chk("mid_rst_no_done", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
